multicycle_controller: RTL and testbench
========================================

// Module: multicycle_controller
// PURPOSE
//  Moore FSM that sequences a multicycle MIPS datapath: one shared memory for instructions and data.
//  Decodes the opcode/funct of the latched instruction.
//  Drives all mux selects and write enables for PC, IR, register file, memory and ALU.
//  Sits between the instruction register and the datapath, replacing the single-cycle control decoder.
//  Stalls on a memory ready handshake and traps to ERROR on memory timeout.
// PARAMETERS
//  TIMEOUT  16  max cycles a memory state waits for mem_ready before entering ERROR (>=2)
// PORTS
//  clk          in   1  rising-edge clock
//  rst_n        in   1  synchronous reset, active-low
//  opcode       in   6  instr[31:26] from instruction register
//  funct        in   6  instr[5:0] from instruction register
//  zero         in   1  ALU zero flag
//  mem_ready    in   1  memory completes the current access this cycle
//  pc_en        out  1  PC load enable = pcwrite | (branch & zero)
//  iord         out  1  memory address select: 0=PC, 1=ALUOut
//  mem_we       out  1  memory write enable
//  ir_we        out  1  instruction register load
//  reg_we       out  1  register file write enable
//  regdst       out  1  write-reg select: 0=rt, 1=rd
//  memtoreg     out  1  write-data select: 0=ALUOut, 1=memory data
//  alusrca      out  1  0=PC, 1=register A
//  alusrcb      out  2  00=reg B, 01=const 4, 10=signimm, 11=signimm<<2
//  pcsrc        out  2  00=ALU result, 01=ALUOut, 10=jump target
//  alucontrol   out  3  010 add, 110 sub, 000 and, 001 or, 111 slt
//  instr_done   out  1  one-cycle pulse in the final cycle of each instruction
//  illegal_op   out  1  one-cycle pulse on unknown opcode or funct in DECODE
//  error        out  1  high while in ERROR
// BEHAVIOUR
//  States:
//   FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE, EXECUTE, ALUWB, BRANCH, ADDIEX, ADDIWB, JUMP, ERROR.
//  Reset:
//   - rst_n=0 at a clock edge: state<=FETCH, wait counter<=0.
//   - While rst_n=0, every enable (pc_en, mem_we, ir_we, reg_we) and every pulse/error output is forced 0.
//   - All selects are 0 during reset.
//  Unlisted outputs are 0 in each state.
//  FETCH:
//   - iord=0, alusrca=0, alusrcb=01, alucontrol=add, pcsrc=00.
//   - ir_we and pc_en are asserted only in a cycle with mem_ready=1; the FSM then moves to DECODE.
//   - With mem_ready=0 it holds in FETCH.
//  DECODE: alusrca=0, alusrcb=11, alucontrol=add. Next state by opcode:
//   - 100011 or 101011 -> MEMADR
//   - 000000 -> EXECUTE
//   - 000100 -> BRANCH
//   - 001000 -> ADDIEX
//   - 000010 -> JUMP
//   - anything else -> FETCH with an illegal_op pulse
//  MEMADR: alusrca=1, alusrcb=10, add. lw -> MEMREAD; sw -> MEMWRITE.
//  MEMREAD: iord=1. Waits for mem_ready, then -> MEMWB.
//  MEMWB: reg_we=1, regdst=0, memtoreg=1, instr_done=1, then -> FETCH.
//  MEMWRITE:
//   - iord=1; mem_we is held high until the cycle with mem_ready=1.
//   - That cycle gives instr_done=1, then -> FETCH.
//  EXECUTE:
//   - alusrca=1, alusrcb=00, alucontrol from funct: 100000 add, 100010 sub, 100100 and, 100101 or, 101010 slt.
//   - Other funct: illegal_op pulse, -> FETCH, no write.
//   - Valid funct -> ALUWB.
//  ALUWB: reg_we=1, regdst=1, memtoreg=0, instr_done=1, then -> FETCH.
//  BRANCH:
//   - alusrca=1, alusrcb=00, sub, pcsrc=01; pc_en=zero.
//   - instr_done=1, then -> FETCH.
//  ADDIEX: alusrca=1, alusrcb=10, add, then -> ADDIWB.
//  ADDIWB: reg_we=1, regdst=0, memtoreg=0, instr_done=1, then -> FETCH.
//  JUMP: pcsrc=10, pc_en=1, instr_done=1, then -> FETCH.
//  Wait counter (FETCH, MEMREAD, MEMWRITE only):
//   - Cleared on entry to a wait state; increments each cycle with mem_ready=0.
//   - If mem_ready=0 in the cycle the counter equals TIMEOUT-1, the next state is ERROR.
//   - If mem_ready=1 in that same cycle, it wins and normal flow continues.
//  ERROR: error=1, all enables 0. Sticky until rst_n=0.
//  Latency (mem_ready always 1), cycles FETCH through last: R 4, lw 5, sw 4, beq 3, addi 4, j 3.
//  Reset mid-instruction aborts it; no enable is asserted in the reset cycle.
// TESTING
//  1. mem_ready=1, opcode=000000, funct=100010:
//     -> FETCH, DECODE, EXECUTE(alucontrol=110), ALUWB(reg_we=1, regdst=1, instr_done=1), FETCH.
//  2. lw (100011), mem_ready low for 3 cycles in MEMREAD:
//     -> MEMREAD lasts 4 cycles with iord=1, then MEMWB with memtoreg=1, reg_we=1; total 8 cycles.
//  3. beq (000100):
//     -> zero=1 gives pc_en=1, pcsrc=01 in BRANCH.
//     -> zero=0 gives pc_en=0; both 3 cycles.
//  4. TIMEOUT=16, mem_ready=0 forever from reset:
//     -> 16 cycles in FETCH, then error=1 and held.
//     -> rst_n=0 for 1 cycle -> FETCH, error=0.
//  5. opcode=111111:
//     -> illegal_op pulse in DECODE, return to FETCH, no reg_we/mem_we.
//     -> funct=000001 with R-type gives the same response from EXECUTE.
//  6. sw with rst_n=0 asserted in MEMWRITE:
//     -> mem_we=0 in the reset cycle, FETCH next, counter 0.

Source files
------------

// File: rtl/multicycle_controller.sv
// Moore control FSM for a multicycle MIPS datapath with one shared instruction/data memory.
// Memory states stall on mem_ready and trap into a sticky ERROR state when the wait times out.
module multicycle_controller #(
  parameter int TIMEOUT = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       pc_en,
  output logic       iord,
  output logic       mem_we,
  output logic       ir_we,
  output logic       reg_we,
  output logic       regdst,
  output logic       memtoreg,
  output logic       alusrca,
  output logic [1:0] alusrcb,
  output logic [1:0] pcsrc,
  output logic [2:0] alucontrol,
  output logic       instr_done,
  output logic       illegal_op,
  output logic       error
);

  localparam int CW = $clog2(TIMEOUT);

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_SLT = 6'b101010;

  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_SLT = 3'b111;

  typedef enum logic [3:0] {
    FETCH,
    DECODE,
    MEMADR,
    MEMREAD,
    MEMWB,
    MEMWRITE,
    EXECUTE,
    ALUWB,
    BRANCH,
    ADDIEX,
    ADDIWB,
    JUMP,
    ERROR
  } state_t;

  state_t          state;
  state_t          next_state;
  logic [CW-1:0]   wait_cnt;
  logic            in_wait_state;
  logic            timeout_hit;
  logic [2:0]      funct_alu;
  logic            funct_ok;

  assign in_wait_state = (state == FETCH) || (state == MEMREAD) || (state == MEMWRITE);
  assign timeout_hit   = (wait_cnt == CW'(TIMEOUT - 1));

  // R-type funct decode, shared by next-state (legality) and outputs (ALU op)
  always_comb begin
    funct_alu = 3'b000;
    funct_ok  = 1'b1;
    case (funct)
      FN_ADD:  funct_alu = ALU_ADD;
      FN_SUB:  funct_alu = ALU_SUB;
      FN_AND:  funct_alu = ALU_AND;
      FN_OR:   funct_alu = ALU_OR;
      FN_SLT:  funct_alu = ALU_SLT;
      default: funct_ok  = 1'b0;
    endcase
  end

  // The wait counter restarts on every state change, so each wait state sees a fresh budget
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= FETCH;
      wait_cnt <= '0;
    end else begin
      state <= next_state;
      if (next_state != state) begin
        wait_cnt <= '0;
      end else if (in_wait_state && !mem_ready) begin
        wait_cnt <= wait_cnt + CW'(1);
      end
    end
  end

  always_comb begin
    next_state = state;
    case (state)
      FETCH: begin
        if (mem_ready)        next_state = DECODE;
        else if (timeout_hit) next_state = ERROR;
      end
      DECODE: begin
        case (opcode)
          OP_LW, OP_SW: next_state = MEMADR;
          OP_RTYPE:     next_state = EXECUTE;
          OP_BEQ:       next_state = BRANCH;
          OP_ADDI:      next_state = ADDIEX;
          OP_J:         next_state = JUMP;
          default:      next_state = FETCH;
        endcase
      end
      MEMADR:   next_state = (opcode == OP_LW) ? MEMREAD : MEMWRITE;
      MEMREAD: begin
        if (mem_ready)        next_state = MEMWB;
        else if (timeout_hit) next_state = ERROR;
      end
      MEMWB:    next_state = FETCH;
      MEMWRITE: begin
        if (mem_ready)        next_state = FETCH;
        else if (timeout_hit) next_state = ERROR;
      end
      EXECUTE:  next_state = funct_ok ? ALUWB : FETCH;
      ALUWB:    next_state = FETCH;
      BRANCH:   next_state = FETCH;
      ADDIEX:   next_state = ADDIWB;
      ADDIWB:   next_state = FETCH;
      JUMP:     next_state = FETCH;
      ERROR:    next_state = ERROR;
      default:  next_state = FETCH;
    endcase
  end

  // Everything stays 0 while rst_n is low, so an aborted instruction never writes in the reset cycle
  always_comb begin
    pc_en      = 1'b0;
    iord       = 1'b0;
    mem_we     = 1'b0;
    ir_we      = 1'b0;
    reg_we     = 1'b0;
    regdst     = 1'b0;
    memtoreg   = 1'b0;
    alusrca    = 1'b0;
    alusrcb    = 2'b00;
    pcsrc      = 2'b00;
    alucontrol = 3'b000;
    instr_done = 1'b0;
    illegal_op = 1'b0;
    error      = 1'b0;
    if (rst_n) begin
      case (state)
        FETCH: begin
          alusrcb    = 2'b01;
          alucontrol = ALU_ADD;
          ir_we      = mem_ready;
          pc_en      = mem_ready;
        end
        DECODE: begin
          alusrcb    = 2'b11;
          alucontrol = ALU_ADD;
          illegal_op = !(opcode inside {OP_LW, OP_SW, OP_RTYPE, OP_BEQ, OP_ADDI, OP_J});
        end
        MEMADR, ADDIEX: begin
          alusrca    = 1'b1;
          alusrcb    = 2'b10;
          alucontrol = ALU_ADD;
        end
        MEMREAD: iord = 1'b1;
        MEMWB: begin
          reg_we     = 1'b1;
          memtoreg   = 1'b1;
          instr_done = 1'b1;
        end
        MEMWRITE: begin
          iord       = 1'b1;
          mem_we     = 1'b1;
          instr_done = mem_ready;
        end
        EXECUTE: begin
          alusrca    = 1'b1;
          alucontrol = funct_alu;
          illegal_op = !funct_ok;
        end
        ALUWB: begin
          reg_we     = 1'b1;
          regdst     = 1'b1;
          instr_done = 1'b1;
        end
        BRANCH: begin
          alusrca    = 1'b1;
          alucontrol = ALU_SUB;
          pcsrc      = 2'b01;
          pc_en      = zero;
          instr_done = 1'b1;
        end
        ADDIWB: begin
          reg_we     = 1'b1;
          instr_done = 1'b1;
        end
        JUMP: begin
          pcsrc      = 2'b10;
          pc_en      = 1'b1;
          instr_done = 1'b1;
        end
        ERROR:   error = 1'b1;
        default: error = 1'b0;
      endcase
    end
  end

endmodule

// File: tb/tb_multicycle_controller.sv
// Self-checking bench for multicycle_controller: an instruction-step reference model checked every
// cycle, directed scenarios with literal expectations, then randomized instruction/stall traffic.
module tb_multicycle_controller;

  localparam int TIMEOUT = 16;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [5:0] opcode = 6'd0;
  logic [5:0] funct = 6'd0;
  logic       zero = 1'b0;
  logic       mem_ready = 1'b0;
  logic       pc_en, iord, mem_we, ir_we, reg_we, regdst, memtoreg, alusrca;
  logic [1:0] alusrcb, pcsrc;
  logic [2:0] alucontrol;
  logic       instr_done, illegal_op, error;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  multicycle_controller #(.TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .funct(funct), .zero(zero),
    .mem_ready(mem_ready), .pc_en(pc_en), .iord(iord), .mem_we(mem_we), .ir_we(ir_we),
    .reg_we(reg_we), .regdst(regdst), .memtoreg(memtoreg), .alusrca(alusrca),
    .alusrcb(alusrcb), .pcsrc(pcsrc), .alucontrol(alucontrol), .instr_done(instr_done),
    .illegal_op(illegal_op), .error(error)
  );

  localparam logic [5:0] LW = 6'b100011, SW = 6'b101011, RT = 6'b000000;
  localparam logic [5:0] BEQ = 6'b000100, ADDI = 6'b001000, JMP = 6'b000010;

  // Reference model: step 0 is the fetch cycle, then cycles are counted within the instruction
  int m_step = 0;
  int m_wait = 0;
  bit m_err = 1'b0;
  bit check_en = 1'b0;

  function automatic bit funct_legal(input logic [5:0] fn);
    return fn inside {6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010};
  endfunction

  function automatic logic [2:0] funct_alu(input logic [5:0] fn);
    case (fn)
      6'b100000: return 3'b010;
      6'b100010: return 3'b110;
      6'b100100: return 3'b000;
      6'b100101: return 3'b001;
      6'b101010: return 3'b111;
      default:   return 3'b000;
    endcase
  endfunction

  function automatic int last_step(input logic [5:0] op, input logic [5:0] fn);
    case (op)
      LW:      return 4;
      SW:      return 3;
      RT:      return funct_legal(fn) ? 3 : 2;
      BEQ:     return 2;
      ADDI:    return 3;
      JMP:     return 2;
      default: return 1;
    endcase
  endfunction

  function automatic bit wait_step(input int step, input logic [5:0] op);
    return (step == 0) || (step == 3 && (op == LW || op == SW));
  endfunction

  function automatic logic [17:0] expect_ctrl(input int step, input bit err, input logic r,
                                              input logic [5:0] op, input logic [5:0] fn,
                                              input logic z, input logic rdy);
    logic pe, io, mw, iw, rw, rd, mr, sa, dn, il, er;
    logic [1:0] sb, ps;
    logic [2:0] ac;
    {pe, io, mw, iw, rw, rd, mr, sa, dn, il, er} = '0;
    sb = 2'b00; ps = 2'b00; ac = 3'b000;
    if (r && err) begin
      er = 1'b1;
    end else if (r) begin
      if (step == 0) begin
        sb = 2'b01; ac = 3'b010; iw = rdy; pe = rdy;
      end else if (step == 1) begin
        sb = 2'b11; ac = 3'b010; il = (last_step(op, fn) == 1);
      end else begin
        case (op)
          LW, SW: begin
            if (step == 2) begin sa = 1'b1; sb = 2'b10; ac = 3'b010; end
            else if (step == 3) begin
              io = 1'b1;
              if (op == SW) begin mw = 1'b1; dn = rdy; end
            end else begin rw = 1'b1; mr = 1'b1; dn = 1'b1; end
          end
          RT: begin
            if (step == 2) begin sa = 1'b1; ac = funct_alu(fn); il = !funct_legal(fn); end
            else begin rw = 1'b1; rd = 1'b1; dn = 1'b1; end
          end
          BEQ: begin sa = 1'b1; ac = 3'b110; ps = 2'b01; pe = z; dn = 1'b1; end
          ADDI: begin
            if (step == 2) begin sa = 1'b1; sb = 2'b10; ac = 3'b010; end
            else begin rw = 1'b1; dn = 1'b1; end
          end
          JMP: begin ps = 2'b10; pe = 1'b1; dn = 1'b1; end
          default: ;
        endcase
      end
    end
    return {pe, io, mw, iw, rw, rd, mr, sa, sb, ps, ac, dn, il, er};
  endfunction

  always @(posedge clk) begin
    if (!rst_n) begin
      m_step <= 0; m_wait <= 0; m_err <= 1'b0;
    end else if (!m_err) begin
      if (wait_step(m_step, opcode) && !mem_ready) begin
        if (m_wait == TIMEOUT - 1) m_err <= 1'b1;
        else m_wait <= m_wait + 1;
      end else begin
        m_wait <= 0;
        m_step <= (m_step == last_step(opcode, funct)) ? 0 : m_step + 1;
      end
    end
  end

  logic [17:0] exp_v, act_v;
  always @(negedge clk) begin
    if (check_en) begin
      exp_v = expect_ctrl(m_step, m_err, rst_n, opcode, funct, zero, mem_ready);
      act_v = {pc_en, iord, mem_we, ir_we, reg_we, regdst, memtoreg, alusrca,
               alusrcb, pcsrc, alucontrol, instr_done, illegal_op, error};
      checks++;
      if (act_v !== exp_v) begin
        errors++;
        $display("[TB] FAIL ctrl t=%0t step=%0d got=%b want=%b", $time, m_step, act_v, exp_v);
      end
    end
  end

  // Inputs change 1 time unit after the edge; opcode/funct only change in a fetch cycle when hold_ir
  task automatic applyStimulus(input logic r, input logic [5:0] op, input logic [5:0] fn,
                               input logic z, input logic rdy, input bit hold_ir);
    @(posedge clk);
    #1;
    rst_n = r;
    if (!(hold_ir && m_step != 0)) begin
      opcode = op;
      funct  = fn;
    end
    zero = z;
    mem_ready = rdy;
    #3;
  endtask

  task automatic checkOutput(input string name, input logic [3:0] got, input logic [3:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("[TB] FAIL %s got=%0d want=%0d", name, got, want);
    end
  endtask

  task automatic doReset();
    applyStimulus(1'b0, opcode, funct, 1'b0, 1'b1, 1'b0);
    applyStimulus(1'b0, opcode, funct, 1'b0, 1'b1, 1'b0);
  endtask

  localparam logic [5:0] LEGAL_OPS [6] = '{LW, SW, RT, BEQ, ADDI, JMP};
  localparam logic [5:0] LEGAL_FNS [5] = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010};

  initial begin
    doReset();
    check_en = 1'b1;
    checkOutput("reset_outputs", {pc_en, ir_we, mem_we, error}, 4'd0);

    // R-type sub
    applyStimulus(1'b1, RT, 6'b100010, 1'b0, 1'b1, 1'b0);
    checkOutput("r_fetch_irwe", {3'd0, ir_we}, 4'd1);
    applyStimulus(1'b1, RT, 6'b100010, 1'b0, 1'b1, 1'b0);
    checkOutput("r_decode_srcb", {2'd0, alusrcb}, 4'd3);
    applyStimulus(1'b1, RT, 6'b100010, 1'b0, 1'b1, 1'b0);
    checkOutput("r_exec_alu", {1'b0, alucontrol}, 4'd6);
    applyStimulus(1'b1, RT, 6'b100010, 1'b0, 1'b1, 1'b0);
    checkOutput("r_aluwb", {1'b0, reg_we, regdst, instr_done}, 4'd7);

    // lw with three stall cycles in MEMREAD
    doReset();
    for (int i = 0; i < 3; i++) applyStimulus(1'b1, LW, 6'd0, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b1, LW, 6'd0, 1'b0, 1'b0, 1'b0);
      checkOutput("lw_memread_iord", {2'd0, iord, reg_we}, 4'd2);
    end
    applyStimulus(1'b1, LW, 6'd0, 1'b0, 1'b1, 1'b0);
    checkOutput("lw_memread_last", {2'd0, iord, instr_done}, 4'd2);
    applyStimulus(1'b1, LW, 6'd0, 1'b0, 1'b1, 1'b0);
    checkOutput("lw_memwb", {1'b0, memtoreg, reg_we, instr_done}, 4'd7);

    // beq taken then not taken
    for (int zb = 1; zb >= 0; zb--) begin
      doReset();
      applyStimulus(1'b1, BEQ, 6'd0, 1'(zb), 1'b1, 1'b0);
      applyStimulus(1'b1, BEQ, 6'd0, 1'(zb), 1'b1, 1'b0);
      applyStimulus(1'b1, BEQ, 6'd0, 1'(zb), 1'b1, 1'b0);
      checkOutput("beq_branch", {pc_en, pcsrc, instr_done}, zb ? 4'b1011 : 4'b0011);
      applyStimulus(1'b1, BEQ, 6'd0, 1'(zb), 1'b1, 1'b0);
      checkOutput("beq_back_fetch", {3'd0, ir_we}, 4'd1);
    end

    // timeout from reset, then recovery
    doReset();
    for (int i = 0; i < TIMEOUT; i++) begin
      applyStimulus(1'b1, RT, 6'b100000, 1'b0, 1'b0, 1'b0);
      checkOutput("timeout_wait", {3'd0, error}, 4'd0);
    end
    applyStimulus(1'b1, RT, 6'b100000, 1'b0, 1'b0, 1'b0);
    checkOutput("timeout_error", {3'd0, error}, 4'd1);
    applyStimulus(1'b1, RT, 6'b100000, 1'b0, 1'b1, 1'b0);
    checkOutput("error_sticky", {ir_we, pc_en, 1'b0, error}, 4'd1);
    applyStimulus(1'b0, RT, 6'b100000, 1'b0, 1'b1, 1'b0);
    checkOutput("error_reset", {3'd0, error}, 4'd0);
    applyStimulus(1'b1, RT, 6'b100000, 1'b0, 1'b1, 1'b0);
    checkOutput("recover_fetch", {ir_we, 2'd0, error}, 4'd8);

    // illegal opcode, then illegal funct
    doReset();
    applyStimulus(1'b1, 6'b111111, 6'd0, 1'b0, 1'b1, 1'b0);
    applyStimulus(1'b1, 6'b111111, 6'd0, 1'b0, 1'b1, 1'b0);
    checkOutput("illegal_opcode", {illegal_op, reg_we, mem_we, 1'b0}, 4'd8);
    applyStimulus(1'b1, RT, 6'b000001, 1'b0, 1'b1, 1'b0);
    checkOutput("illegal_op_refetch", {illegal_op, 2'd0, ir_we}, 4'd1);
    applyStimulus(1'b1, RT, 6'b000001, 1'b0, 1'b1, 1'b0);
    checkOutput("rtype_decode_ok", {3'd0, illegal_op}, 4'd0);
    applyStimulus(1'b1, RT, 6'b000001, 1'b0, 1'b1, 1'b0);
    checkOutput("illegal_funct", {illegal_op, reg_we, mem_we, 1'b0}, 4'd8);
    applyStimulus(1'b1, RT, 6'b000001, 1'b0, 1'b1, 1'b0);
    checkOutput("illegal_fn_refetch", {3'd0, ir_we}, 4'd1);

    // sw aborted by reset inside MEMWRITE; the counter must restart from 0
    doReset();
    for (int i = 0; i < 3; i++) applyStimulus(1'b1, SW, 6'd0, 1'b0, 1'b1, 1'b0);
    applyStimulus(1'b1, SW, 6'd0, 1'b0, 1'b0, 1'b0);
    checkOutput("sw_memwrite", {2'd0, mem_we, iord}, 4'd3);
    applyStimulus(1'b0, SW, 6'd0, 1'b0, 1'b0, 1'b0);
    checkOutput("sw_reset_cycle", {2'd0, mem_we, iord}, 4'd0);
    applyStimulus(1'b1, SW, 6'd0, 1'b0, 1'b0, 1'b0);
    checkOutput("sw_after_reset", {ir_we, mem_we, iord, error}, 4'd0);
    for (int i = 0; i < TIMEOUT - 1; i++) applyStimulus(1'b1, SW, 6'd0, 1'b0, 1'b0, 1'b0);
    checkOutput("sw_counter_clear", {3'd0, error}, 4'd0);
    applyStimulus(1'b1, SW, 6'd0, 1'b0, 1'b0, 1'b0);
    checkOutput("sw_timeout", {3'd0, error}, 4'd1);

    // randomized traffic with alternating fast and starved memory epochs
    doReset();
    for (int epoch = 0; epoch < 15; epoch++) begin
      int p_ready;
      p_ready = (epoch % 3 == 2) ? 8 : 80;
      for (int c = 0; c < 200; c++) begin
        logic [5:0] op, fn;
        op = ($urandom_range(0, 9) == 0) ? 6'($urandom) : LEGAL_OPS[$urandom_range(0, 5)];
        fn = ($urandom_range(0, 4) == 0) ? 6'($urandom) : LEGAL_FNS[$urandom_range(0, 4)];
        applyStimulus(($urandom_range(0, 99) >= 2), op, fn, 1'($urandom_range(0, 1)),
                      ($urandom_range(0, 99) < p_ready), 1'b1);
      end
    end

    @(posedge clk);
    #1;
    check_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
